jt10_adpcmb_rom_if: RTL

JT10_ADPCMB_ROM_IF -- requirements
Module: jt10_adpcmb_rom_if

---
 rtl/jt10_adpcmb_rom_if.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/jt10_adpcmb_rom_if.sv
// jt10_adpcmb_rom_if: byte fetch bridge between the ADPCM-B driver read
// strobe and an external memory with a req/ok handshake and a timeout.
// Optional single-entry address cache: define JT10_ADPCMB_CACHE_EN.
module jt10_adpcmb_rom_if #(
  parameter int AW   = 24,
  parameter int TOUT = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          roe_n,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ok,
  input  logic [7:0]    mem_data,
  output logic          err
);

  localparam int CW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
  localparam logic [CW:0] TOUT_C = (CW + 1)'(TOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_q;
  logic          roe_n_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] pend_addr_q;
  logic          pend_v_q;
  logic [7:0]    data_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_req_q;
  logic          err_q;
  logic          hit_q;

  logic          request;
  logic          hit;
  logic [CW:0]   cnt_inc;
  logic          timeout;

  // falling edge of the read strobe against its registered copy
  assign request = roe_n_q & ~roe_n;

  // timeout fires on the WAIT cycle that brings the count up to TOUT
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign timeout = (cnt_inc >= TOUT_C);

`ifdef JT10_ADPCMB_CACHE_EN
  logic [AW-1:0] tag_q;
  logic          tag_v_q;

  assign hit = request & tag_v_q & (addr == tag_q);

  // tag tracks the last successfully fetched address; a timeout discards it
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      tag_v_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (mem_ok) begin
        tag_q   <= mem_addr_q;
        tag_v_q <= 1'b1;
      end else if (timeout) begin
        tag_v_q <= 1'b0;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  // main fetch FSM with registered outputs and one-deep pending slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      roe_n_q     <= 1'b1;
      cnt_q       <= '0;
      pend_addr_q <= '0;
      pend_v_q    <= 1'b0;
      data_q      <= 8'h00;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      err_q       <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      roe_n_q <= roe_n;
      hit_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (request) begin
            if (hit) begin
              // cached: data already holds this byte, just flag busy once
              hit_q <= 1'b1;
            end else begin
              mem_addr_q <= addr;
              mem_req_q  <= 1'b1;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          mem_req_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT;
          if (request) begin
            pend_addr_q <= addr;
            pend_v_q    <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_inc[CW-1:0];
          if (mem_ok || timeout) begin
            mem_req_q <= 1'b0;
            if (mem_ok) begin
              data_q <= mem_data;
            end else begin
              data_q <= 8'h00;
              err_q  <= 1'b1;
            end
            // a strobe landing on the completion cycle is newer than any
            // pending address, so it is the one that gets serviced
            if (request) begin
              mem_addr_q <= addr;
              pend_v_q   <= 1'b0;
              state_q    <= REQ;
            end else if (pend_v_q) begin
              mem_addr_q <= pend_addr_q;
              pend_v_q   <= 1'b0;
              state_q    <= REQ;
            end else begin
              state_q    <= IDLE;
            end
          end else if (request) begin
            pend_addr_q <= addr;
            pend_v_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data     = data_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) | pend_v_q | hit_q;

endmodule
